axi_vga_regfile: RTL and testbench
==================================

Name: axi_vga_regfile

Overview:
Parametrised AXI4-Lite slave register file for the VGA IP family. It is the next generation of the fixed 4-register VGA slave and adds:
- configurable read/write and read-only register counts
- byte strobes
- independent AW/W acceptance
- a write-1-to-clear interrupt status register with an enable mask
- SLVERR on unmapped addresses

It sits between the block-design AXI interconnect and the VGA timing/pixel core.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is legal.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2^width >= 4*(NUM_RW+NUM_RO+2).
NUM_RW, 8, number of read/write control registers (1..16).
NUM_RO, 4, number of read-only status registers (0..16).

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset; synchronous, active-low
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  OKAY=00, SLVERR=10
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
ctrl_regs  out  32*NUM_RW  RW register contents, reg k at bits [32k+31:32k]
status_in  in  32*NUM_RO  sampled live on reads
irq_event  in  32  per-bit level event, sets status while high
irq  out  1  registered OR of (irq_status & irq_enable)

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. Reset is synchronous and active-low on S_AXI_ARESETN.
- Register map (word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored):
  - 0..NUM_RW-1: RW registers
  - NUM_RW..NUM_RW+NUM_RO-1: RO registers
  - NUM_RW+NUM_RO: IRQ_STATUS (W1C)
  - NUM_RW+NUM_RO+1: IRQ_ENABLE (RW)
  - Higher indices are unmapped.
- Reset (ARESETN=0 at an edge), at the following edge:
  - all ctrl_regs, IRQ_STATUS, IRQ_ENABLE, irq = 0
  - AWREADY, WREADY, ARREADY = 0 during reset; they rise the first cycle after reset deasserts
  - BVALID, RVALID = 0; BRESP, RRESP = 00; RDATA = 0
  - aw_held and w_held cleared
  - Reset mid-transaction aborts it silently; no response is issued.
- Write channel:
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - AW and W are accepted independently in either order or in the same cycle. Address, data and strobe are latched on their handshake edges.
  - Commit happens on the first edge where aw_held && w_held. At that edge:
    - RW/IRQ_ENABLE: bytes with WSTRB[b]=1 are written.
    - IRQ_STATUS: bits are cleared where (WDATA & byte-mask) = 1.
    - RO: ignored, BRESP=OKAY.
    - Unmapped: no state change, BRESP=SLVERR.
    - BVALID rises at the same edge; held flags clear.
  - Minimum latency: AW+W handshake at edge N gives commit and BVALID at edge N+1.
  - BVALID holds until BREADY. No new AW/W is accepted while BVALID=1.
- Read channel:
  - ARREADY = !RVALID.
  - On the handshake edge, RDATA/RRESP are registered and RVALID rises.
  - Unmapped address returns RDATA=0, RRESP=SLVERR.
  - RO registers return status_in sampled at the handshake edge.
  - RDATA/RVALID hold stable until RREADY. Back-to-back reads give one transfer per 2 cycles minimum.
- Reads and writes are fully concurrent. A read of a register committed at the same edge returns the pre-write value.
- IRQ:
  - Each edge: IRQ_STATUS <= (IRQ_STATUS & ~clear_mask) | irq_event.
  - An event and a W1C clear in the same cycle leave the bit set (set wins).
  - irq is registered: irq(t+1) = |(IRQ_STATUS(t) & IRQ_ENABLE(t)).

Test Plan:
- Reset values: after reset, read all 14 indices (default parameters) -> RW, IRQ_STATUS and IRQ_ENABLE read 0 with OKAY; index 14 and 15 return 0 with SLVERR; irq=0.
- Sequential write/read: write 0x1..0x8 to addr 0x00..0x1C with WSTRB=F, read back -> data matches, ctrl_regs slice k = k+1, BRESP/RRESP=OKAY.
- Byte strobes: write 0xAABBCCDD, then 0x11223344 with WSTRB=0101 to addr 0x04 -> reads 0xAA22CC44.
- Channel ordering: W issued 3 cycles before AW -> WREADY low after the W handshake, commit one edge after the AW handshake. Hold BREADY=0 for 5 cycles -> BVALID held, AWREADY/WREADY=0 throughout.
- RO and unmapped: status_in[0]=0xDEADBEEF, write 0 to 0x20 -> BRESP=OKAY and a read returns 0xDEADBEEF. Write to 0x38 -> SLVERR, no register changes.
- IRQ: IRQ_ENABLE=0x1, pulse irq_event[0] one cycle -> IRQ_STATUS=0x1 and irq=1 two edges after the pulse. Write 0x1 to IRQ_STATUS -> irq=0. Repeat with the event coinciding with the clear edge -> bit stays 1.

Source files
------------

// File: rtl/axi_vga_regfile.sv
// AXI4-Lite slave register file for the VGA IP family.
// Word map: RW control registers, RO status registers, IRQ_STATUS (W1C),
// IRQ_ENABLE. Anything above IRQ_ENABLE answers SLVERR.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// VALID and READY are both high. A source holds VALID and its payload stable
// until that edge; a sink may drive READY independently of VALID. This slave
// never makes READY depend combinationally on an incoming VALID.
module axi_vga_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_RW             = 8,
  parameter int NUM_RO             = 4
) (
  input  logic                                           S_AXI_ACLK,
  input  logic                                           S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                  S_AXI_AWADDR,
  input  logic [2:0]                                     S_AXI_AWPROT,
  input  logic                                           S_AXI_AWVALID,
  output logic                                           S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                  S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                S_AXI_WSTRB,
  input  logic                                           S_AXI_WVALID,
  output logic                                           S_AXI_WREADY,
  output logic [1:0]                                     S_AXI_BRESP,
  output logic                                           S_AXI_BVALID,
  input  logic                                           S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                  S_AXI_ARADDR,
  input  logic [2:0]                                     S_AXI_ARPROT,
  input  logic                                           S_AXI_ARVALID,
  output logic                                           S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                  S_AXI_RDATA,
  output logic [1:0]                                     S_AXI_RRESP,
  output logic                                           S_AXI_RVALID,
  input  logic                                           S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_RW-1:0]           ctrl_regs,
  input  logic [C_S_AXI_DATA_WIDTH*(NUM_RO > 0 ? NUM_RO : 1)-1:0] status_in,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                  irq_event,
  output logic                                           irq
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STAT_IDX = NUM_RW + NUM_RO;
  localparam int EN_IDX   = NUM_RW + NUM_RO + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register state
  logic [DW-1:0]    ctrl_q [NUM_RW];
  logic [DW-1:0]    irq_status_q;
  logic [DW-1:0]    irq_enable_q;
  logic             irq_q;

  // Write channel state
  logic             ready_en_q;
  logic             aw_held_q;
  logic             w_held_q;
  logic [IDX_W-1:0] aw_idx_q;
  logic [DW-1:0]    w_data_q;
  logic [SW-1:0]    w_strb_q;
  logic             bvalid_q;
  logic [1:0]       bresp_q;

  // Read channel state
  logic             rvalid_q;
  logic [1:0]       rresp_q;
  logic [DW-1:0]    rdata_q;

  // Combinational helpers
  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             commit;
  int               w_idx;
  int               r_idx;
  logic             w_err;
  logic [DW-1:0]    byte_mask;
  logic [DW-1:0]    wr_merge;
  logic [DW-1:0]    clear_mask;
  logic [DW-1:0]    rd_word;
  logic             rd_err;
  logic             unused_bits;

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ready_en_q keeps every READY low while reset is asserted and lets them
  // rise on the first cycle after release.
  assign S_AXI_AWREADY = ready_en_q && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = ready_en_q && !w_held_q  && !bvalid_q;
  assign S_AXI_ARREADY = ready_en_q && !rvalid_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = aw_held_q && w_held_q;

  assign w_idx  = int'(aw_idx_q);
  assign r_idx  = int'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign w_err  = (w_idx > EN_IDX);

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;
  assign irq          = irq_q;

  // Expose the control registers as one flat vector, register k in slice k.
  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl_out
    assign ctrl_regs[DW*g +: DW] = ctrl_q[g];
  end

  // Expand latched strobes into a bit mask and pre-merge the new word.
  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < SW; b++) begin
      byte_mask[8*b +: 8] = {8{w_strb_q[b]}};
    end
    wr_merge = w_data_q & byte_mask;
  end

  // W1C clear mask: only live on a commit that targets IRQ_STATUS.
  always_comb begin
    clear_mask = '0;
    if (commit && (w_idx == STAT_IDX)) begin
      clear_mask = wr_merge;
    end
  end

  // Read mux: decode the live AR address to a word and a response.
  always_comb begin
    rd_word = '0;
    rd_err  = 1'b1;
    for (int k = 0; k < NUM_RW; k++) begin
      if (r_idx == k) begin
        rd_word = ctrl_q[k];
        rd_err  = 1'b0;
      end
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (r_idx == NUM_RW + k) begin
        rd_word = status_in[DW*k +: DW];
        rd_err  = 1'b0;
      end
    end
    if (r_idx == STAT_IDX) begin
      rd_word = irq_status_q;
      rd_err  = 1'b0;
    end
    if (r_idx == EN_IDX) begin
      rd_word = irq_enable_q;
      rd_err  = 1'b0;
    end
  end

  // Reset-release tracker that gates the READY outputs.
  always_ff @(posedge S_AXI_ACLK) begin
    ready_en_q <= S_AXI_ARESETN;
  end

  // AW/W capture: each side latches independently; both clear on commit.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Write response: raised by the commit, dropped when the master takes it.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= w_err ? RESP_SLVERR : RESP_OKAY;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // Control registers: strobed byte merge on a commit to their index.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      for (int k = 0; k < NUM_RW; k++) begin
        ctrl_q[k] <= '0;
      end
    end else if (commit) begin
      for (int k = 0; k < NUM_RW; k++) begin
        if (w_idx == k) begin
          ctrl_q[k] <= (ctrl_q[k] & ~byte_mask) | wr_merge;
        end
      end
    end
  end

  // IRQ enable register: strobed byte merge.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      irq_enable_q <= '0;
    end else if (commit && (w_idx == EN_IDX)) begin
      irq_enable_q <= (irq_enable_q & ~byte_mask) | wr_merge;
    end
  end

  // IRQ status: W1C clear applied first so a same-cycle event keeps the bit.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      irq_status_q <= '0;
    end else begin
      irq_status_q <= (irq_status_q & ~clear_mask) | irq_event;
    end
  end

  // Interrupt line: registered OR of enabled pending bits.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(irq_status_q & irq_enable_q);
    end
  end

  // Read channel: capture data on AR handshake, hold until RREADY.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      rdata_q  <= rd_word;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_vga_regfile.sv
// Self-checking bench for axi_vga_regfile with default parameters.
// Reference model: plain arrays for the RW registers plus IRQ words.
module tb_axi_vga_regfile;

  localparam int NRW      = 8;
  localparam int NRO      = 4;
  localparam int STAT_IDX = 12;
  localparam int EN_IDX   = 13;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic [5:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [5:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [255:0] ctrl_regs;
  logic [127:0] status_in;
  logic [31:0]  irq_event;
  logic         irq;

  axi_vga_regfile dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (aresetn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .ctrl_regs     (ctrl_regs),
    .status_in     (status_in),
    .irq_event     (irq_event),
    .irq           (irq)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] rw_m [NRW];
  logic [31:0] st_m;
  logic [31:0] en_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) m = m + (32'hFF << (8 * b));
    end
    return m;
  endfunction

  // Model of a committed write; returns the response the slave must give.
  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    logic [31:0] m;
    m    = strb_mask(s);
    resp = 2'b00;
    if (idx < NRW)            rw_m[idx] = (rw_m[idx] & ~m) | (d & m);
    else if (idx < STAT_IDX)  resp = 2'b00;
    else if (idx == STAT_IDX) st_m = st_m & ~(d & m);
    else if (idx == EN_IDX)   en_m = (en_m & ~m) | (d & m);
    else                      resp = 2'b10;
  endtask

  task automatic model_read(input int idx, output logic [31:0] d, output logic [1:0] resp);
    resp = 2'b00;
    d    = 32'h0;
    if (idx < NRW)            d = rw_m[idx];
    else if (idx < STAT_IDX)  d = status_in[32*(idx-NRW) +: 32];
    else if (idx == STAT_IDX) d = st_m;
    else if (idx == EN_IDX)   d = en_m;
    else                      resp = 2'b10;
  endtask

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int   n;
    logic aw_hs;
    logic w_hs;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin
      tick();
      n++;
    end
    chk("bvalid_seen", {31'h0, bvalid}, 32'h1);
    resp = bresp;
    tick();
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int   n;
    logic hs;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 50) begin
      hs = arready;
      tick();
      if (hs) arvalid = 1'b0;
      n++;
    end
    arvalid = 1'b0;
    chk("rvalid_after_ar", {31'h0, rvalid}, 32'h1);
    d    = rdata;
    resp = rresp;
    tick();
  endtask

  task automatic do_write(input int idx, input logic [31:0] d, input logic [3:0] s, input string tag);
    logic [1:0] exp_resp;
    logic [1:0] got_resp;
    model_write(idx, d, s, exp_resp);
    axi_write(6'(idx * 4), d, s, got_resp);
    chk({tag, "_bresp"}, {30'h0, got_resp}, {30'h0, exp_resp});
  endtask

  task automatic do_read(input int idx, input string tag);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    logic [31:0] got_d;
    logic [1:0]  got_r;
    model_read(idx, exp_d, exp_r);
    axi_read(6'(idx * 4), got_d, got_r);
    chk({tag, "_rdata"}, got_d, exp_d);
    chk({tag, "_rresp"}, {30'h0, got_r}, {30'h0, exp_r});
  endtask

  task automatic chk_ctrl(input string tag);
    for (int k = 0; k < NRW; k++) begin
      chk($sformatf("%s_ctrl%0d", tag, k), ctrl_regs[32*k +: 32], rw_m[k]);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    irq_event = '0;
    status_in = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < NRW; k++) rw_m[k] = 32'h0;
    st_m = 32'h0;
    en_m = 32'h0;

    // Reset: readies low while held in reset, rise one cycle after release
    repeat (3) tick();
    chk("rst_awready", {31'h0, awready}, 32'h0);
    chk("rst_wready",  {31'h0, wready},  32'h0);
    chk("rst_arready", {31'h0, arready}, 32'h0);
    chk("rst_bvalid",  {31'h0, bvalid},  32'h0);
    chk("rst_rvalid",  {31'h0, rvalid},  32'h0);
    chk("rst_rdata",   rdata, 32'h0);
    chk("rst_irq",     {31'h0, irq},     32'h0);
    aresetn = 1'b1;
    tick();
    chk("post_rst_awready", {31'h0, awready}, 32'h1);
    chk("post_rst_wready",  {31'h0, wready},  32'h1);
    chk("post_rst_arready", {31'h0, arready}, 32'h1);
    chk_ctrl("rst");

    // Reset values over the whole map, including two unmapped words
    for (int i = 0; i < 16; i++) do_read(i, $sformatf("rst_rd%0d", i));

    // Sequential write/read of RW registers
    for (int i = 0; i < NRW; i++) do_write(i, 32'(i + 1), 4'hF, $sformatf("seq_wr%0d", i));
    for (int i = 0; i < NRW; i++) do_read(i, $sformatf("seq_rd%0d", i));
    chk_ctrl("seq");

    // Byte strobes
    do_write(1, 32'hAABBCCDD, 4'hF, "strb_full");
    do_write(1, 32'h11223344, 4'b0101, "strb_part");
    do_read(1, "strb_rd");
    chk("strb_const", ctrl_regs[63:32], 32'hAA22CC44);

    // Channel ordering: W three cycles ahead of AW, then stalled B
    wdata = 32'h5A5A0001; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    chk("ord_wready_pre", {31'h0, wready}, 32'h1);
    tick();
    wvalid = 1'b0;
    chk("ord_wready_held", {31'h0, wready}, 32'h0);
    tick();
    tick();
    chk("ord_no_commit_yet", ctrl_regs[95:64], rw_m[2]);
    awaddr = 6'h08; awvalid = 1'b1;
    chk("ord_awready_pre", {31'h0, awready}, 32'h1);
    tick();
    awvalid = 1'b0;
    chk("ord_bvalid_early", {31'h0, bvalid}, 32'h0);
    tick();
    rw_m[2] = 32'h5A5A0001;
    chk("ord_bvalid", {31'h0, bvalid}, 32'h1);
    chk("ord_bresp",  {30'h0, bresp},  32'h0);
    chk("ord_ctrl2",  ctrl_regs[95:64], rw_m[2]);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ord_hold_bvalid%0d", i),  {31'h0, bvalid},  32'h1);
      chk($sformatf("ord_hold_awready%0d", i), {31'h0, awready}, 32'h0);
      chk($sformatf("ord_hold_wready%0d", i),  {31'h0, wready},  32'h0);
      tick();
    end
    bready = 1'b1;
    tick();
    chk("ord_bvalid_done", {31'h0, bvalid}, 32'h0);

    // RO and unmapped
    status_in[31:0] = 32'hDEADBEEF;
    do_write(8, 32'h0, 4'hF, "ro_wr");
    do_read(8, "ro_rd");
    do_write(14, 32'hFFFFFFFF, 4'hF, "unm_wr");
    chk_ctrl("unm");
    do_read(STAT_IDX, "unm_stat");
    do_read(EN_IDX, "unm_en");

    // Randomized writes/reads across the whole map
    for (int t = 0; t < 40; t++) begin
      int idx;
      idx = $urandom_range(0, 15);
      if (idx == STAT_IDX || idx == EN_IDX) idx = $urandom_range(0, 11);
      status_in = {$urandom, $urandom, $urandom, $urandom};
      do_write(idx, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd_wr%0d", t));
      do_read($urandom_range(0, 15), $sformatf("rnd_rd%0d", t));
    end
    chk_ctrl("rnd");

    // IRQ: enable bit 0, pulse event, check two-edge latency
    do_write(EN_IDX, 32'h1, 4'hF, "irq_en");
    chk("irq_idle", {31'h0, irq}, 32'h0);
    irq_event = 32'h1;
    tick();
    irq_event = 32'h0;
    st_m = 32'h1;
    chk("irq_edge1", {31'h0, irq}, 32'h0);
    tick();
    chk("irq_edge2", {31'h0, irq}, 32'h1);
    do_read(STAT_IDX, "irq_stat_set");
    do_write(STAT_IDX, 32'h1, 4'hF, "irq_clr");
    chk("irq_after_clr", {31'h0, irq}, 32'h0);
    do_read(STAT_IDX, "irq_stat_clr");

    // IRQ: event coinciding with the clearing commit edge keeps the bit set
    irq_event = 32'h1;
    tick();
    irq_event = 32'h0;
    tick();
    awaddr = 6'h30; wdata = 32'h1; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    chk("coin_awready", {31'h0, awready}, 32'h1);
    chk("coin_wready",  {31'h0, wready},  32'h1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    irq_event = 32'h1;
    tick();
    irq_event = 32'h0;
    chk("coin_bvalid", {31'h0, bvalid}, 32'h1);
    tick();
    st_m = 32'h1;
    do_read(STAT_IDX, "coin_stat");
    chk("coin_irq", {31'h0, irq}, 32'h1);
    do_write(STAT_IDX, 32'hFFFFFFFF, 4'hF, "coin_clr");
    do_read(STAT_IDX, "coin_stat_clr");
    chk("coin_irq_clr", {31'h0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
